// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: two requesters share one W-bit, 8-function ALU.
// Round-robin arbitration in IDLE, W-cycle restoring divider for div/mod,
// and a result register held in DONE until the consumer takes it.
//
// Handshake rule (all three ports): a transfer happens in a cycle where
// valid && ready are both high at the rising clock edge. Ready never depends
// on anything but state, the request valids and the round-robin pointer.
// A requester may drop valid before it sees ready.
module alu_rr_sequencer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_sel,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_sel,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W:0]   res_data,
  output logic         res_id,
  output logic         res_err,
  output logic [1:0]   dbg_state,
  output logic         dbg_rr_ptr
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic           id_q, id_d;
  logic [W-1:0]   b_q, b_d;
  logic           is_mod_q, is_mod_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     res_data_q, res_data_d;
  logic           res_err_q, res_err_d;

  logic           grant_id;
  logic           idle;
  logic           hs;
  logic [W-1:0]   in_a, in_b;
  logic [2:0]     in_sel;
  logic           in_is_div;
  logic [W:0]     alu_out;
  logic [W:0]     trial;
  logic           ge;
  logic [W-1:0]   rem_sub, rem_nxt, quo_nxt;

  // Arbitration: a lone valid wins; with both valid the pointer decides.
  always_comb begin
    grant_id   = req0_valid ? (req1_valid ? rr_ptr_q : 1'b0) : 1'b1;
    idle       = (state_q == S_IDLE) && !rst;
    req0_ready = idle && req0_valid && !grant_id;
    req1_ready = idle && req1_valid && grant_id;
    hs         = req0_ready || req1_ready;
    in_a       = grant_id ? req1_a   : req0_a;
    in_b       = grant_id ? req1_b   : req0_b;
    in_sel     = grant_id ? req1_sel : req0_sel;
    in_is_div  = (in_sel == 3'b011) || (in_sel == 3'b100);
  end

  // Single-cycle functions on the granted operands; div/mod only reaches here
  // when b is zero, in which case the result is all ones.
  always_comb begin
    alu_out = '0;
    case (in_sel)
      3'b000:  alu_out = {1'b0, in_a};
      3'b001:  alu_out = {1'b0, in_a} + {1'b0, in_b};
      3'b010:  alu_out = {1'b0, in_a} - {1'b0, in_b};
      3'b101:  alu_out = {in_a, 1'b0};
      3'b110:  alu_out = {1'b0, in_a} >> 1;
      3'b111:  alu_out = {{W{1'b0}}, (in_a > in_b)};
      default: alu_out = '1;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder,
  // subtract the divisor when it fits and record the quotient bit.
  always_comb begin
    trial   = {rem_q, quo_q[W-1]};
    ge      = trial >= {1'b0, b_q};
    rem_sub = trial[W-1:0] - b_q;
    rem_nxt = ge ? rem_sub : trial[W-1:0];
    quo_nxt = {quo_q[W-2:0], ge};
  end

  // Next-state and datapath updates for IDLE / DIV / DONE.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    b_d        = b_q;
    is_mod_d   = is_mod_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          id_d     = grant_id;
          b_d      = in_b;
          is_mod_d = (in_sel == 3'b100);
          if (in_is_div && (in_b != '0)) begin
            state_d = S_DIV;
            quo_d   = in_a;
            rem_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d    = S_DONE;
            res_data_d = alu_out;
            res_err_d  = in_is_div;
          end
        end
      end
      S_DIV: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d    = S_DONE;
          res_data_d = is_mod_q ? {1'b0, rem_nxt} : {1'b0, quo_nxt};
          res_err_d  = 1'b0;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d  = S_IDLE;
          rr_ptr_d = ~id_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 1'b0;
      id_q       <= 1'b0;
      b_q        <= '0;
      is_mod_q   <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      b_q        <= b_d;
      is_mod_q   <= is_mod_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  assign res_valid  = (state_q == S_DONE);
  assign res_data   = res_data_q;
  assign res_id     = id_q;
  assign res_err    = res_err_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule
